// File: rtl/ma_pkg.sv
// Shared definitions for the memory-access stage: FSM states, AMO flag indices,
// access-size encoding and the byte-lane shift helper.
package ma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        AMO_RD = 3'd3,
        AMO_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Bit positions of the one-hot AMO flags in io_ops.amo
    localparam int AMO_SWAP = 0;
    localparam int AMO_ADD  = 1;
    localparam int AMO_XOR  = 2;
    localparam int AMO_AND  = 3;
    localparam int AMO_OR   = 4;
    localparam int AMO_MIN  = 5;
    localparam int AMO_MAX  = 6;
    localparam int AMO_MINU = 7;
    localparam int AMO_MAXU = 8;
    localparam int AMO_NUM  = 9;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam int SZ_UNSIGNED = 2;

    function automatic logic [5:0] laneShift(input logic [2:0] offset);
        return {offset, 3'b000};
    endfunction

endpackage

// File: rtl/io_ops.sv
// Operation flags carried by the EX/MA register into the memory-access stage.
interface io_ops;
    logic                load;
    logic                store;
    logic                lr;
    logic                sc;
    logic [8:0]          amo;
    logic [2:0]          size;
    logic [7:0]          mask;

    modport dst (input load, store, lr, sc, amo, size, mask);
    modport src (output load, store, lr, sc, amo, size, mask);
endinterface

// File: rtl/ma_load_ext.sv
// Picks the addressed bytes out of a full bus doubleword and sign/zero-extends
// them to 64 bits.
module ma_load_ext
    import ma_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_offset,
    input  logic [2:0]  i_size,
    output logic [63:0] o_value
);

    logic [63:0] w_shifted;
    logic        w_signed;

    assign w_shifted = i_rdata >> laneShift(i_offset);
    assign w_signed  = ~i_size[SZ_UNSIGNED];

    always_comb begin
        case (i_size[1:0])
            SZ_B:    o_value = {{56{w_signed & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_value = {{48{w_signed & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_value = {{32{w_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_value = w_shifted;
        endcase
    end

endmodule

// File: rtl/stage_ma.sv
// Memory-access pipeline stage: loads, stores, LR/SC and AMO read-modify-write
// on a simple req/ready data bus, stalling upstream while a transaction is open.
module stage_ma
    import ma_pkg::*;
#(
    parameter int XW      = 64,
    parameter int RSV_LSB = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] pc_in,
    input  logic [4:0]    rd_in,
    input  logic [63:0]   result_in,
    input  logic [63:0]   data2_in,
    io_ops.dst            io_ops_in,
    output logic [XW-1:0] pc_out,
    output logic [4:0]    rd_out,
    output logic [63:0]   result_out,
    output logic          stall_out,
    output logic          bus_req,
    output logic          bus_we,
    output logic [63:0]   bus_addr,
    output logic [63:0]   bus_wdata,
    output logic [7:0]    bus_mask,
    input  logic          bus_ready,
    input  logic [63:0]   bus_rdata
);

    state_t              r_state;
    state_t              w_next;
    logic [63:0]         r_addr;
    logic [63:0]         r_data2;
    logic [63:0]         r_result;
    logic [4:0]          r_rd;
    logic [2:0]          r_size;
    logic [7:0]          r_mask;
    logic                r_isLr;
    logic [AMO_NUM-1:0]  r_amo;
    logic                r_rsvValid;
    logic [63:RSV_LSB]   r_rsvAddr;

    logic                w_isAmo;
    logic                w_memOp;
    logic                w_rsvHit;
    logic [2:0]          w_extSize;
    logic [63:0]         w_ext;
    logic                w_isWord;
    logic [63:0]         w_opA;
    logic [63:0]         w_opB;
    logic [63:0]         w_opAU;
    logic [63:0]         w_opBU;
    logic                w_lt;
    logic                w_ltu;
    logic [63:0]         w_amoNew;

    assign w_isAmo  = |io_ops_in.amo;
    assign w_memOp  = io_ops_in.load | io_ops_in.store | io_ops_in.lr | io_ops_in.sc | w_isAmo;
    assign w_rsvHit = r_rsvValid && (r_rsvAddr == result_in[63:RSV_LSB]);

    // AMO old values are always sign-extended, regardless of the unsigned flag
    assign w_extSize = (r_state == AMO_RD) ? {1'b0, r_size[1:0]} : r_size;

    ma_load_ext u_loadExt (
        .i_rdata  (bus_rdata),
        .i_offset (r_addr[2:0]),
        .i_size   (w_extSize),
        .o_value  (w_ext)
    );

    assign w_isWord = (r_size[1:0] == SZ_W);
    assign w_opA    = w_ext;
    assign w_opB    = w_isWord ? {{32{r_data2[31]}}, r_data2[31:0]} : r_data2;
    assign w_opAU   = w_isWord ? {32'b0, w_opA[31:0]} : w_opA;
    assign w_opBU   = w_isWord ? {32'b0, w_opB[31:0]} : w_opB;
    assign w_lt     = $signed(w_opA) < $signed(w_opB);
    assign w_ltu    = w_opAU < w_opBU;

    always_comb begin
        w_amoNew = w_opB;
        if      (r_amo[AMO_ADD])  w_amoNew = w_opA + w_opB;
        else if (r_amo[AMO_XOR])  w_amoNew = w_opA ^ w_opB;
        else if (r_amo[AMO_AND])  w_amoNew = w_opA & w_opB;
        else if (r_amo[AMO_OR])   w_amoNew = w_opA | w_opB;
        else if (r_amo[AMO_MIN])  w_amoNew = w_lt  ? w_opA : w_opB;
        else if (r_amo[AMO_MAX])  w_amoNew = w_lt  ? w_opB : w_opA;
        else if (r_amo[AMO_MINU]) w_amoNew = w_ltu ? w_opA : w_opB;
        else if (r_amo[AMO_MAXU]) w_amoNew = w_ltu ? w_opB : w_opA;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_memOp) begin
                    if (io_ops_in.load || io_ops_in.lr) w_next = RD;
                    else if (io_ops_in.store)           w_next = WR;
                    else if (w_isAmo)                   w_next = AMO_RD;
                    else                                w_next = w_rsvHit ? WR : DONE;
                end
            end
            RD:      if (bus_ready) w_next = DONE;
            WR:      if (bus_ready) w_next = DONE;
            AMO_RD:  if (bus_ready) w_next = AMO_WR;
            AMO_WR:  if (bus_ready) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transaction context is latched on acceptance so the bus sees stable values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_data2    <= '0;
            r_result   <= '0;
            r_rd       <= '0;
            r_size     <= '0;
            r_mask     <= '0;
            r_isLr     <= 1'b0;
            r_amo      <= '0;
            r_rsvValid <= 1'b0;
            r_rsvAddr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        r_addr   <= result_in;
                        r_data2  <= data2_in;
                        r_rd     <= rd_in;
                        r_size   <= io_ops_in.size;
                        r_mask   <= io_ops_in.mask;
                        r_isLr   <= io_ops_in.lr;
                        r_amo    <= io_ops_in.amo;
                        r_result <= (io_ops_in.sc && !w_rsvHit) ? 64'd1 : 64'd0;
                        if (io_ops_in.sc || ((io_ops_in.store || w_isAmo) && w_rsvHit))
                            r_rsvValid <= 1'b0;
                    end
                end
                RD: begin
                    if (bus_ready) begin
                        r_result <= w_ext;
                        if (r_isLr) begin
                            r_rsvValid <= 1'b1;
                            r_rsvAddr  <= r_addr[63:RSV_LSB];
                        end
                    end
                end
                AMO_RD: begin
                    if (bus_ready) begin
                        r_result <= w_ext;
                        r_data2  <= w_amoNew;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_out     = pc_in;
        rd_out     = '0;
        result_out = r_result;
        stall_out  = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = {r_addr[63:3], 3'b000};
        bus_wdata  = r_data2 << laneShift(r_addr[2:0]);
        bus_mask   = r_mask;
        case (r_state)
            IDLE: begin
                stall_out  = w_memOp;
                rd_out     = w_memOp ? 5'd0 : rd_in;
                result_out = result_in;
            end
            RD, AMO_RD: begin
                stall_out = 1'b1;
                bus_req   = 1'b1;
            end
            WR, AMO_WR: begin
                stall_out = 1'b1;
                bus_req   = 1'b1;
                bus_we    = 1'b1;
            end
            DONE: begin
                rd_out = r_rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stage_ma.sv
// Directed scoreboard bench for stage_ma: each op pushes its expected writeback,
// which is popped and compared when the stage leaves its stall.
module tb_stage_ma;
    import ma_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_in;
    logic [4:0]  rd_in;
    logic [63:0] result_in;
    logic [63:0] data2_in;
    logic [63:0] pc_out;
    logic [4:0]  rd_out;
    logic [63:0] result_out;
    logic        stall_out;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_mask;
    logic        bus_ready;
    logic [63:0] bus_rdata;

    io_ops ops();

    always #5 clk = ~clk;

    stage_ma #(.XW(64), .RSV_LSB(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .rd_in      (rd_in),
        .result_in  (result_in),
        .data2_in   (data2_in),
        .io_ops_in  (ops),
        .pc_out     (pc_out),
        .rd_out     (rd_out),
        .result_out (result_out),
        .stall_out  (stall_out),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_mask   (bus_mask),
        .bus_ready  (bus_ready),
        .bus_rdata  (bus_rdata)
    );

    typedef enum {K_LOAD, K_STORE, K_LR, K_SC, K_AMO} kind_e;

    typedef struct {
        string       tag;
        logic [4:0]  rd;
        logic [63:0] res;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic clearOps();
        ops.load  = 1'b0;
        ops.store = 1'b0;
        ops.lr    = 1'b0;
        ops.sc    = 1'b0;
        ops.amo   = '0;
        ops.size  = '0;
        ops.mask  = '0;
    endtask

    // Drives one memory op into IDLE, plays the bus side, and checks the writeback
    task automatic applyStimulus(
        input string       tag,
        input kind_e       kind,
        input int          amoIdx,
        input logic [2:0]  size,
        input logic [7:0]  mask,
        input logic [63:0] addr,
        input logic [63:0] data2,
        input logic [63:0] rdata,
        input logic [4:0]  rd,
        input int          waits,
        input logic [63:0] expRes,
        input int          expPhases,
        input bit          expWrite,
        input logic [63:0] expWdata,
        input int          expStall
    );
        exp_t        e;
        exp_t        got;
        int          stallCnt;
        int          waitCnt;
        int          phases;
        bit          wrSeen;
        bit          done;
        logic [63:0] laneMask;

        @(negedge clk);
        clearOps();
        case (kind)
            K_LOAD:  ops.load  = 1'b1;
            K_STORE: ops.store = 1'b1;
            K_LR:    ops.lr    = 1'b1;
            K_SC:    ops.sc    = 1'b1;
            default: ops.amo[amoIdx] = 1'b1;
        endcase
        ops.size  = size;
        ops.mask  = mask;
        result_in = addr;
        data2_in  = data2;
        rd_in     = rd;
        bus_ready = 1'b0;
        e.tag = tag;
        e.rd  = rd;
        e.res = expRes;
        sb.push_back(e);
        #1;
        checkOutput({tag, ".stallAccept"}, 64'(stall_out), 64'd1);
        checkOutput({tag, ".rdAccept"}, 64'(rd_out), 64'd0);

        stallCnt = 1;
        waitCnt  = 0;
        phases   = 0;
        wrSeen   = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            bus_ready = 1'b0;
            if (bus_req) begin
                waitCnt++;
                if (waitCnt > waits) begin
                    bus_ready = 1'b1;
                    bus_rdata = rdata;
                end
            end
            #1;
            if (stall_out) begin
                stallCnt++;
                if (bus_ready) begin
                    phases++;
                    waitCnt = 0;
                    checkOutput({tag, ".rdStall"}, 64'(rd_out), 64'd0);
                    checkOutput({tag, ".busAddr"}, bus_addr, {addr[63:3], 3'b000});
                    checkOutput({tag, ".busMask"}, 64'(bus_mask), 64'(mask));
                    if (bus_we) begin
                        wrSeen = 1'b1;
                        for (int b = 0; b < 8; b++)
                            laneMask[b*8 +: 8] = {8{mask[b]}};
                        checkOutput({tag, ".busWdata"}, bus_wdata & laneMask, expWdata & laneMask);
                    end
                end
            end else begin
                done = 1'b1;
                got  = sb.pop_front();
                checkOutput({got.tag, ".rdOut"}, 64'(rd_out), 64'(got.rd));
                checkOutput({got.tag, ".resultOut"}, result_out, got.res);
                checkOutput({tag, ".busPhases"}, 64'(phases), 64'(expPhases));
                checkOutput({tag, ".busWrite"}, 64'(wrSeen), 64'(expWrite));
                if (expStall >= 0)
                    checkOutput({tag, ".stallCycles"}, 64'(stallCnt), 64'(expStall));
                clearOps();
            end
        end
        if (!done) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s.timeout: observed no completion expected completion within 64 cycles", tag);
            void'(sb.pop_front());
            clearOps();
            bus_ready = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        pc_in     = 64'h8000_0000;
        rd_in     = '0;
        result_in = '0;
        data2_in  = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        clearOps();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset.busReq", 64'(bus_req), 64'd0);
        checkOutput("reset.busWe", 64'(bus_we), 64'd0);
        checkOutput("reset.stall", 64'(stall_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU pass-through happens in the same cycle
        @(negedge clk);
        rd_in     = 5'd5;
        result_in = 64'h1234;
        pc_in     = 64'h8000_0040;
        #1;
        checkOutput("pass.rd", 64'(rd_out), 64'd5);
        checkOutput("pass.result", result_out, 64'h1234);
        checkOutput("pass.stall", 64'(stall_out), 64'd0);
        checkOutput("pass.busReq", 64'(bus_req), 64'd0);
        checkOutput("pass.pc", pc_out, 64'h8000_0040);

        applyStimulus("lb", K_LOAD, 0, 3'b000, 8'h08, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
                      5'd1, 0, 64'hFFFF_FFFF_FFFF_FF80, 1, 1'b0, 64'h0, 2);
        applyStimulus("lbu", K_LOAD, 0, 3'b100, 8'h08, 64'h1003, 64'h0, 64'h0000_0000_8000_0000,
                      5'd2, 0, 64'h80, 1, 1'b0, 64'h0, 2);
        applyStimulus("lhu", K_LOAD, 0, 3'b101, 8'hC0, 64'h1006, 64'h0, 64'hABCD_0000_0000_0000,
                      5'd3, 2, 64'hABCD, 1, 1'b0, 64'h0, 4);
        applyStimulus("lw", K_LOAD, 0, 3'b010, 8'hF0, 64'h1004, 64'h0, 64'h8000_0001_0000_0000,
                      5'd4, 0, 64'hFFFF_FFFF_8000_0001, 1, 1'b0, 64'h0, 2);
        applyStimulus("ld", K_LOAD, 0, 3'b111, 8'hFF, 64'h1008, 64'h0, 64'h0123_4567_89AB_CDEF,
                      5'd5, 1, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 64'h0, 3);
        applyStimulus("sh", K_STORE, 0, 3'b001, 8'hC0, 64'h2006, 64'hBEEF, 64'h0,
                      5'd0, 4, 64'h0, 1, 1'b1, 64'hBEEF_0000_0000_0000, 6);
        applyStimulus("amoaddw", K_AMO, AMO_ADD, 3'b010, 8'h0F, 64'h3000, 64'h1, 64'h0000_0000_7FFF_FFFF,
                      5'd6, 0, 64'h0000_0000_7FFF_FFFF, 2, 1'b1, 64'h0000_0000_8000_0000, 3);
        applyStimulus("amomaxw", K_AMO, AMO_MAX, 3'b010, 8'hF0, 64'h3004, 64'h5, 64'hFFFF_FFFF_0000_0000,
                      5'd7, 1, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1, 64'h0000_0005_0000_0000, 5);

        applyStimulus("lrd", K_LR, 0, 3'b011, 8'hFF, 64'h4000, 64'h0, 64'h55,
                      5'd8, 0, 64'h55, 1, 1'b0, 64'h0, 2);
        applyStimulus("scdPass", K_SC, 0, 3'b011, 8'hFF, 64'h4000, 64'hAA, 64'h0,
                      5'd9, 0, 64'h0, 1, 1'b1, 64'hAA, 2);
        applyStimulus("scdFail", K_SC, 0, 3'b011, 8'hFF, 64'h4000, 64'hBB, 64'h0,
                      5'd10, 0, 64'h1, 0, 1'b0, 64'h0, 1);

        // A store to the reserved doubleword kills the reservation
        applyStimulus("lrd2", K_LR, 0, 3'b011, 8'hFF, 64'h4000, 64'h0, 64'h66,
                      5'd11, 0, 64'h66, 1, 1'b0, 64'h0, 2);
        applyStimulus("sdClr", K_STORE, 0, 3'b011, 8'hFF, 64'h4000, 64'h77, 64'h0,
                      5'd0, 0, 64'h0, 1, 1'b1, 64'h77, 2);
        applyStimulus("scdAfterSd", K_SC, 0, 3'b011, 8'hFF, 64'h4000, 64'hCC, 64'h0,
                      5'd12, 0, 64'h1, 0, 1'b0, 64'h0, 1);

        // Reset in the middle of a read abandons it and drops the reservation
        applyStimulus("lrd3", K_LR, 0, 3'b011, 8'hFF, 64'h4000, 64'h0, 64'h99,
                      5'd13, 0, 64'h99, 1, 1'b0, 64'h0, 2);
        @(negedge clk);
        ops.load  = 1'b1;
        ops.size  = 3'b011;
        ops.mask  = 8'hFF;
        result_in = 64'h5000;
        rd_in     = 5'd14;
        bus_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstMid.busReqBefore", 64'(bus_req), 64'd1);
        rst = 1'b1;
        clearOps();
        @(negedge clk);
        #1;
        checkOutput("rstMid.busReq", 64'(bus_req), 64'd0);
        checkOutput("rstMid.stall", 64'(stall_out), 64'd0);
        rst = 1'b0;
        applyStimulus("scdAfterRst", K_SC, 0, 3'b011, 8'hFF, 64'h4000, 64'hDD, 64'h0,
                      5'd15, 0, 64'h1, 0, 1'b0, 64'h0, 1);

        checkOutput("scoreboard.empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
